// File: rtl/vga_draw_gen.sv
// Pixel generator: background pattern plus NUM_OBJ square overlays, RGB565 out.
// Two register stages; object attributes are double-buffered and committed at frame start.
module vga_draw_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int NUM_OBJ  = 4,
  parameter int OBJ_SIZE = 16,
  parameter int IW       = 3
) (
  input  logic          iVGA_CLK,
  input  logic          reset_n,
  input  logic [XW-1:0] iVGA_X,
  input  logic [YW-1:0] iVGA_Y,
  input  logic [1:0]    iMode,
  input  logic          iColor_SW,
  input  logic          iObj_we,
  input  logic [IW-1:0] iObj_idx,
  input  logic [XW-1:0] iObj_x,
  input  logic [YW-1:0] iObj_y,
  input  logic [15:0]   iObj_color,
  input  logic          iObj_en,
  input  logic          iObj_blink,
  output logic [15:0]   oRGB,
  output logic          oFrame_start
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [NUM_OBJ-1:0][XW-1:0] r_sh_x, r_act_x, w_cur_x;
  logic [NUM_OBJ-1:0][YW-1:0] r_sh_y, r_act_y, w_cur_y;
  logic [NUM_OBJ-1:0][15:0]   r_sh_col, r_act_col, w_cur_col;
  logic [NUM_OBJ-1:0]         r_sh_en, r_act_en, w_cur_en;
  logic [NUM_OBJ-1:0]         r_sh_blink, r_act_blink, w_cur_blink;
  logic [7:0]                 r_frame_cnt, w_frame_cnt_cur;

  logic                       w_frame_start;
  logic                       w_in_range;
  logic [2:0]                 w_bar;
  logic [15:0]                w_bg;
  logic [NUM_OBJ-1:0]         w_hit;

  logic                       r_s1_in_range;
  logic [15:0]                r_s1_bg;
  logic [NUM_OBJ-1:0]         r_s1_hit;
  logic [NUM_OBJ-1:0][15:0]   r_s1_col;
  logic                       r_s1_fs;

  logic [15:0]                w_rgb;
  logic                       w_found;

  assign w_frame_start = (iVGA_X == '0) && (iVGA_Y == '0);
  assign w_in_range    = ({1'b0, iVGA_X} < (XW+1)'(H_ACTIVE)) &&
                         ({1'b0, iVGA_Y} < (YW+1)'(V_ACTIVE));

  // Shadow registers: writable at any time, indices beyond NUM_OBJ never match.
  always_ff @(posedge iVGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_sh_x     <= '0;
      r_sh_y     <= '0;
      r_sh_col   <= '0;
      r_sh_en    <= '0;
      r_sh_blink <= '0;
    end else if (iObj_we) begin
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
        if (iObj_idx == IW'(i)) begin
          r_sh_x[i]     <= iObj_x;
          r_sh_y[i]     <= iObj_y;
          r_sh_col[i]   <= iObj_color;
          r_sh_en[i]    <= iObj_en;
          r_sh_blink[i] <= iObj_blink;
        end
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_act_x     <= '0;
      r_act_y     <= '0;
      r_act_col   <= '0;
      r_act_en    <= '0;
      r_act_blink <= '0;
      r_frame_cnt <= '0;
    end else if (w_frame_start) begin
      r_act_x     <= r_sh_x;
      r_act_y     <= r_sh_y;
      r_act_col   <= r_sh_col;
      r_act_en    <= r_sh_en;
      r_act_blink <= r_sh_blink;
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  // Pixel (0,0) must already see the committed set, so bypass the active copy on that cycle.
  assign w_cur_x         = w_frame_start ? r_sh_x     : r_act_x;
  assign w_cur_y         = w_frame_start ? r_sh_y     : r_act_y;
  assign w_cur_col       = w_frame_start ? r_sh_col   : r_act_col;
  assign w_cur_en        = w_frame_start ? r_sh_en    : r_act_en;
  assign w_cur_blink     = w_frame_start ? r_sh_blink : r_act_blink;
  assign w_frame_cnt_cur = w_frame_start ? (r_frame_cnt + 8'd1) : r_frame_cnt;

  // Edge sums are one bit wider so objects near the right/bottom clip instead of wrapping.
  always_comb begin
    w_hit = '0;
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      w_hit[i] = w_cur_en[i] &&
                 !(w_cur_blink[i] && w_frame_cnt_cur[5]) &&
                 (iVGA_X >= w_cur_x[i]) &&
                 ({1'b0, iVGA_X} < ({1'b0, w_cur_x[i]} + (XW+1)'(OBJ_SIZE))) &&
                 (iVGA_Y >= w_cur_y[i]) &&
                 ({1'b0, iVGA_Y} < ({1'b0, w_cur_y[i]} + (YW+1)'(OBJ_SIZE)));
    end
  end

  always_comb begin
    w_bar = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if ({1'b0, iVGA_X} >= (XW+1)'(k * BAR_W)) begin
        w_bar = 3'(k);
      end
    end
    if (iColor_SW) begin
      w_bar = ~w_bar;
    end
  end

  always_comb begin
    w_bg = '0;
    case (iMode)
      2'd0: w_bg = iColor_SW ? '1 : '0;
      2'd1: begin
        case (w_bar)
          3'd0: w_bg = 16'hFFFF;
          3'd1: w_bg = 16'hFFE0;
          3'd2: w_bg = 16'h07FF;
          3'd3: w_bg = 16'h07E0;
          3'd4: w_bg = 16'hF81F;
          3'd5: w_bg = 16'hF800;
          3'd6: w_bg = 16'h001F;
          3'd7: w_bg = 16'h0000;
        endcase
      end
      2'd2: w_bg = {16{iVGA_X[5] ^ iVGA_Y[5] ^ iColor_SW}};
      2'd3: w_bg = {iVGA_X[9:5], iVGA_Y[8:3], iVGA_X[4:0]} ^ {16{iColor_SW}};
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_in_range <= 1'b0;
      r_s1_bg       <= '0;
      r_s1_hit      <= '0;
      r_s1_col      <= '0;
      r_s1_fs       <= 1'b0;
    end else begin
      r_s1_in_range <= w_in_range;
      r_s1_bg       <= w_bg;
      r_s1_hit      <= w_hit;
      r_s1_col      <= w_cur_col;
      r_s1_fs       <= w_frame_start;
    end
  end

  always_comb begin
    w_rgb   = r_s1_bg;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      if (r_s1_hit[i] && !w_found) begin
        w_rgb   = r_s1_col[i];
        w_found = 1'b1;
      end
    end
    if (!r_s1_in_range) begin
      w_rgb = '0;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      oRGB         <= '0;
      oFrame_start <= 1'b0;
    end else begin
      oRGB         <= w_rgb;
      oFrame_start <= r_s1_fs;
    end
  end

endmodule

// File: tb/tb_vga_draw_gen.sv
// Bench for vga_draw_gen: constant vector table, directed multi-cycle sequences
// and randomized pixels/writes checked against a behavioural frame model.
module tb_vga_draw_gen;
  localparam int NOBJ = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  x, y, ox, oy;
  logic [1:0]  mode;
  logic        sw, we, oen, oblink;
  logic [2:0]  idx;
  logic [15:0] ocol;
  logic [15:0] rgb;
  logic        fs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_draw_gen #(
    .H_ACTIVE(640), .V_ACTIVE(480), .XW(10), .YW(10),
    .NUM_OBJ(NOBJ), .OBJ_SIZE(16), .IW(3)
  ) dut (
    .iVGA_CLK(clk), .reset_n(rst_n), .iVGA_X(x), .iVGA_Y(y),
    .iMode(mode), .iColor_SW(sw), .iObj_we(we), .iObj_idx(idx),
    .iObj_x(ox), .iObj_y(oy), .iObj_color(ocol), .iObj_en(oen),
    .iObj_blink(oblink), .oRGB(rgb), .oFrame_start(fs)
  );

  typedef struct {
    int x; int y; logic [1:0] mode; logic sw;
    logic we; int idx; int ox; int oy; logic [15:0] col; logic en; logic blink;
  } vin_t;
  typedef struct { logic [15:0] rgb; logic fs; string tag; } exp_t;
  typedef struct { int x; int y; logic [1:0] mode; logic sw; logic [15:0] rgb; logic fs; } tv_t;
  typedef struct { int x; int y; logic [15:0] col; bit en; bit blink; } obj_t;

  obj_t        m_sh[NOBJ];
  obj_t        m_ac[NOBJ];
  int          m_fcnt;
  exp_t        q[$];
  logic [15:0] bar_col[8];
  tv_t         tab[19];

  function automatic vin_t px(int px_x, int px_y, logic [1:0] m, logic s);
    vin_t v;
    v.x = px_x; v.y = px_y; v.mode = m; v.sw = s;
    v.we = 1'b0; v.idx = 0; v.ox = 0; v.oy = 0; v.col = 16'h0; v.en = 1'b0; v.blink = 1'b0;
    return v;
  endfunction

  function automatic vin_t wr(vin_t b, int i, int wx, int wy, logic [15:0] c, logic e, logic bl);
    b.we = 1'b1; b.idx = i; b.ox = wx; b.oy = wy; b.col = c; b.en = e; b.blink = bl;
    return b;
  endfunction

  function automatic logic [15:0] ref_bg(int px_x, int px_y, logic [1:0] m, logic s);
    int b;
    logic [15:0] g;
    logic [15:0] r;
    r = 16'h0;
    case (m)
      2'd0: r = s ? 16'hFFFF : 16'h0000;
      2'd1: begin
        b = px_x / 80;
        if (s) b = 7 - b;
        r = bar_col[b];
      end
      2'd2: r = ((((px_x / 32) % 2) ^ ((px_y / 32) % 2) ^ int'(s)) != 0) ? 16'hFFFF : 16'h0000;
      default: begin
        g = 16'(((px_x / 32) % 32) * 2048 + ((px_y / 8) % 64) * 32 + (px_x % 32));
        r = s ? ~g : g;
      end
    endcase
    return r;
  endfunction

  function automatic logic [15:0] ref_pix(int px_x, int px_y, logic [1:0] m, logic s);
    logic [15:0] r;
    bit found;
    found = 1'b0;
    r = 16'h0;
    if (px_x < 640 && px_y < 480) begin
      for (int i = 0; i < NOBJ; i++) begin
        if (!found && m_ac[i].en &&
            px_x >= m_ac[i].x && px_x < m_ac[i].x + 16 &&
            px_y >= m_ac[i].y && px_y < m_ac[i].y + 16 &&
            !(m_ac[i].blink && ((m_fcnt / 32) % 2 == 1))) begin
          r = m_ac[i].col;
          found = 1'b1;
        end
      end
      if (!found) r = ref_bg(px_x, px_y, m, s);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NOBJ; i++) begin
      m_sh[i] = '{0, 0, 16'h0, 1'b0, 1'b0};
      m_ac[i] = '{0, 0, 16'h0, 1'b0, 1'b0};
    end
    m_fcnt = 0;
  endtask

  task automatic model_step(input vin_t v, output logic [15:0] r, output logic f);
    f = (v.x == 0 && v.y == 0);
    if (f) begin
      m_ac = m_sh;
      m_fcnt = (m_fcnt + 1) % 256;
    end
    r = ref_pix(v.x, v.y, v.mode, v.sw);
    if (v.we && v.idx < NOBJ) begin
      m_sh[v.idx].x     = v.ox;
      m_sh[v.idx].y     = v.oy;
      m_sh[v.idx].col   = v.col;
      m_sh[v.idx].en    = v.en;
      m_sh[v.idx].blink = v.blink;
    end
  endtask

  task automatic compare(input exp_t e);
    checks++;
    if (rgb !== e.rgb) begin
      errors++;
      $display("FAIL %s: oRGB=%h expected %h", e.tag, rgb, e.rgb);
    end
    checks++;
    if (fs !== e.fs) begin
      errors++;
      $display("FAIL %s: oFrame_start=%b expected %b", e.tag, fs, e.fs);
    end
  endtask

  // One pixel per clock; the result of a vector is compared two clocks after it is driven.
  task automatic cyc(input vin_t v, input bit own, input logic [15:0] er, input logic ef, input string tag);
    exp_t e;
    logic [15:0] mr;
    logic mf;
    @(negedge clk);
    if (q.size() >= 2) compare(q.pop_front());
    x = 10'(v.x); y = 10'(v.y); mode = v.mode; sw = v.sw;
    we = v.we; idx = 3'(v.idx); ox = 10'(v.ox); oy = 10'(v.oy);
    ocol = v.col; oen = v.en; oblink = v.blink;
    model_step(v, mr, mf);
    e.rgb = own ? er : mr;
    e.fs  = own ? ef : mf;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic chk(input vin_t v, input logic [15:0] er, input logic ef, input string tag);
    cyc(v, 1'b1, er, ef, tag);
  endtask

  task automatic mdl(input vin_t v, input string tag);
    cyc(v, 1'b0, 16'h0, 1'b0, tag);
  endtask

  task automatic flush();
    repeat (2) mdl(px(700, 500, 2'd0, 1'b0), "flush");
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    x = 10'd700; y = 10'd500; we = 1'b0;
    #1;
    checks++;
    if (rgb !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rgb: oRGB=%h expected 0000", rgb);
    end
    checks++;
    if (fs !== 1'b0) begin
      errors++;
      $display("FAIL reset_fs: oFrame_start=%b expected 0", fs);
    end
    repeat (2) @(negedge clk);
    q.delete();
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    x = 10'd700; y = 10'd500; mode = 2'd0; sw = 1'b0; we = 1'b0; idx = 3'd0;
    ox = 10'd0; oy = 10'd0; ocol = 16'h0; oen = 1'b0; oblink = 1'b0;
    bar_col = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    tab[0]  = '{0,   0,   2'd1, 1'b0, 16'hFFFF, 1'b1};
    tab[1]  = '{79,  5,   2'd1, 1'b0, 16'hFFFF, 1'b0};
    tab[2]  = '{80,  5,   2'd1, 1'b0, 16'hFFE0, 1'b0};
    tab[3]  = '{159, 5,   2'd1, 1'b0, 16'hFFE0, 1'b0};
    tab[4]  = '{160, 5,   2'd1, 1'b0, 16'h07FF, 1'b0};
    tab[5]  = '{400, 5,   2'd1, 1'b0, 16'hF800, 1'b0};
    tab[6]  = '{560, 5,   2'd1, 1'b0, 16'h0000, 1'b0};
    tab[7]  = '{639, 5,   2'd1, 1'b0, 16'h0000, 1'b0};
    tab[8]  = '{640, 5,   2'd1, 1'b1, 16'h0000, 1'b0};
    tab[9]  = '{0,   5,   2'd1, 1'b1, 16'h0000, 1'b0};
    tab[10] = '{639, 5,   2'd1, 1'b1, 16'hFFFF, 1'b0};
    tab[11] = '{80,  5,   2'd1, 1'b1, 16'h001F, 1'b0};
    tab[12] = '{10,  480, 2'd0, 1'b1, 16'h0000, 1'b0};
    tab[13] = '{3,   3,   2'd0, 1'b1, 16'hFFFF, 1'b0};
    tab[14] = '{32,  0,   2'd2, 1'b0, 16'hFFFF, 1'b0};
    tab[15] = '{32,  32,  2'd2, 1'b0, 16'h0000, 1'b0};
    tab[16] = '{33,  9,   2'd3, 1'b0, 16'h0821, 1'b0};
    tab[17] = '{33,  9,   2'd3, 1'b1, 16'hF7DE, 1'b0};
    tab[18] = '{100, 200, 2'd2, 1'b1, 16'h0000, 1'b0};
    model_reset();

    do_reset();
    for (int i = 0; i < $size(tab); i++) begin
      chk(px(tab[i].x, tab[i].y, tab[i].mode, tab[i].sw), tab[i].rgb, tab[i].fs, $sformatf("tab%0d", i));
    end
    flush();

    // Object visible, then reset mid-frame hides it until rewritten.
    chk(wr(px(10, 5, 2'd1, 1'b0), 0, 100, 100, 16'hF800, 1'b1, 1'b0), 16'hFFFF, 1'b0, "pre_wr");
    chk(px(0, 0, 2'd1, 1'b0), 16'hFFFF, 1'b1, "pre_fs");
    chk(px(100, 100, 2'd1, 1'b0), 16'hF800, 1'b0, "pre_obj");
    repeat (3) chk(px(10, 5, 2'd1, 1'b0), 16'hFFFF, 1'b0, "pre_run");
    do_reset();
    chk(px(0, 0, 2'd1, 1'b0), 16'hFFFF, 1'b1, "post_rst_fs");
    chk(px(100, 100, 2'd1, 1'b0), 16'hFFE0, 1'b0, "post_rst_hidden");

    // Priority.
    chk(wr(px(300, 200, 2'd0, 1'b0), 0, 100, 100, 16'hF800, 1'b1, 1'b0), 16'h0000, 1'b0, "prio_wr0");
    chk(wr(px(301, 200, 2'd0, 1'b0), 1, 108, 100, 16'h001F, 1'b1, 1'b0), 16'h0000, 1'b0, "prio_wr1");
    chk(px(108, 100, 2'd0, 1'b0), 16'h0000, 1'b0, "prio_cur_frame");
    chk(px(0, 0, 2'd0, 1'b0), 16'h0000, 1'b1, "prio_fs");
    chk(px(108, 100, 2'd0, 1'b0), 16'hF800, 1'b0, "prio_overlap");
    chk(px(116, 100, 2'd0, 1'b0), 16'h001F, 1'b0, "prio_obj1");
    chk(px(124, 100, 2'd0, 1'b0), 16'h0000, 1'b0, "prio_bg");
    chk(px(100, 100, 2'd0, 1'b0), 16'hF800, 1'b0, "prio_obj0_corner");
    chk(px(123, 115, 2'd0, 1'b0), 16'h001F, 1'b0, "prio_obj1_corner");
    chk(px(99, 100, 2'd0, 1'b0), 16'h0000, 1'b0, "prio_left_miss");

    // Out-of-range index write is dropped.
    chk(wr(px(300, 200, 2'd0, 1'b1), 4, 0, 0, 16'h1234, 1'b1, 1'b0), 16'hFFFF, 1'b0, "idx_wr");
    chk(px(0, 0, 2'd0, 1'b1), 16'hFFFF, 1'b1, "idx_ignored");

    // Right-edge clipping.
    chk(wr(px(300, 200, 2'd0, 1'b1), 2, 632, 200, 16'h07E0, 1'b1, 1'b0), 16'hFFFF, 1'b0, "clip_wr");
    chk(px(0, 0, 2'd0, 1'b1), 16'hFFFF, 1'b1, "clip_fs");
    chk(px(632, 200, 2'd0, 1'b1), 16'h07E0, 1'b0, "clip_left");
    chk(px(639, 215, 2'd0, 1'b1), 16'h07E0, 1'b0, "clip_right");
    chk(px(640, 200, 2'd0, 1'b1), 16'h0000, 1'b0, "clip_oor");
    chk(px(0, 200, 2'd0, 1'b1), 16'hFFFF, 1'b0, "clip_nowrap0");
    chk(px(7, 200, 2'd0, 1'b1), 16'hFFFF, 1'b0, "clip_nowrap7");
    chk(px(631, 200, 2'd0, 1'b1), 16'hFFFF, 1'b0, "clip_before");
    chk(px(632, 216, 2'd0, 1'b1), 16'hFFFF, 1'b0, "clip_below");

    // Write in the same cycle as frame start.
    chk(wr(px(50, 50, 2'd0, 1'b0), 3, 200, 300, 16'h001F, 1'b1, 1'b0), 16'h0000, 1'b0, "wfs_wr_old");
    chk(px(0, 0, 2'd0, 1'b0), 16'h0000, 1'b1, "wfs_fs1");
    chk(px(200, 300, 2'd0, 1'b0), 16'h001F, 1'b0, "wfs_old");
    chk(wr(px(0, 0, 2'd0, 1'b0), 3, 200, 300, 16'h07FF, 1'b1, 1'b0), 16'h0000, 1'b1, "wfs_wr_on_fs");
    chk(px(215, 315, 2'd0, 1'b0), 16'h001F, 1'b0, "wfs_old_kept");
    chk(px(0, 0, 2'd0, 1'b0), 16'h0000, 1'b1, "wfs_fs3");
    chk(px(215, 315, 2'd0, 1'b0), 16'h07FF, 1'b0, "wfs_new");

    // Blink: frame counter is 0 after reset and each (0,0) advances it.
    do_reset();
    chk(wr(px(300, 200, 2'd0, 1'b0), 0, 100, 100, 16'hF800, 1'b1, 1'b1), 16'h0000, 1'b0, "blink_wr");
    for (int f = 1; f <= 65; f++) begin
      chk(px(0, 0, 2'd0, 1'b0), 16'h0000, 1'b1, $sformatf("blink_fs%0d", f));
      chk(px(100, 100, 2'd0, 1'b0), ((f % 64) >= 32) ? 16'h0000 : 16'hF800, 1'b0,
          $sformatf("blink_f%0d", f));
    end

    // Randomized pixels and writes against the frame model.
    for (int n = 0; n < 3000; n++) begin
      vin_t v;
      int   oi, px_x, px_y;
      if (n % 40 == 0) begin
        v = px(0, 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 9) < 5) begin
          oi   = int'($urandom_range(0, NOBJ - 1));
          px_x = m_ac[oi].x + int'($urandom_range(0, 19)) - 2;
          px_y = m_ac[oi].y + int'($urandom_range(0, 19)) - 2;
          if (px_x < 0) px_x = 0;
          if (px_y < 0) px_y = 0;
        end else begin
          px_x = int'($urandom_range(0, 700));
          px_y = int'($urandom_range(0, 520));
        end
        v = px(px_x, px_y, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 9) == 0) begin
        v = wr(v, int'($urandom_range(0, 7)), int'($urandom_range(0, 660)), int'($urandom_range(0, 500)),
               16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
      end
      mdl(v, "rand");
    end
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
